// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the four-requester arbiter.
package arb_pkg;

   localparam int NREQ = 4;
   localparam int ID_W = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   function automatic logic [NREQ-1:0] id2onehot(input logic [ID_W-1:0] id);
      logic [NREQ-1:0] oh;
      oh     = '0;
      oh[id] = 1'b1;
      return oh;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational winner select: rotating lowest-set search (rr=1) or highest-set-bit encode (rr=0).
module rr_pick4
   import arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] last_id,
   input  logic            rr,
   output logic [ID_W-1:0] win_id,
   output logic            any
);

   logic [ID_W-1:0] base;
   logic [NREQ-1:0] rot;
   logic [ID_W-1:0] rot_idx;

   always_comb begin
      base    = last_id + ID_W'(1);
      rot     = '0;
      rot_idx = '0;
      win_id  = '0;
      // rot[0] is the requester just past the last winner
      for (int i = 0; i < NREQ; i++) begin
         rot[i] = req[ID_W'(i) + base];
      end
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) rot_idx = ID_W'(i);
      end
      if (rr) begin
         win_id = rot_idx + base;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) win_id = ID_W'(i);
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/arb4_rr_ctrl.sv
// Four-requester arbiter with registered one-hot grants, fixed or round-robin priority,
// and optional hold-time preemption in round-robin mode.
module arb4_rr_ctrl
   import arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16,
   parameter int unsigned CNT_W    = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] req,
   input  logic            rr_mode,
   output logic [NREQ-1:0] gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            gnt_valid,
   output logic            preempt
);

   localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);
   localparam logic             HOLD_LIM  = (MAX_HOLD != 0);

   state_e          state_q, state_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [ID_W-1:0] gnt_id_q, gnt_id_d;
   logic [ID_W-1:0] last_id_q, last_id_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic            preempt_q, preempt_d;
   logic            mode_q, mode_d;
   logic [ID_W-1:0] win_id;
   logic            any_req;

   rr_pick4 u_pick (
      .req     (req),
      .last_id (last_id_q),
      .rr      (rr_mode),
      .win_id  (win_id),
      .any     (any_req)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      gnt_id_d   = gnt_id_q;
      last_id_d  = last_id_q;
      hold_cnt_d = hold_cnt_q;
      mode_d     = mode_q;
      preempt_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               state_d    = ST_GRANT;
               gnt_d      = id2onehot(win_id);
               gnt_id_d   = win_id;
               last_id_d  = win_id;
               mode_d     = rr_mode;
               hold_cnt_d = '0;
            end
         end
         ST_GRANT: begin
            if (!req[gnt_id_q]) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
            end else if (mode_q && HOLD_LIM && (hold_cnt_q == HOLD_LAST) &&
                         (|(req & ~gnt_q))) begin
               // Hold budget spent and someone else is waiting
               state_d   = ST_IDLE;
               gnt_d     = '0;
               preempt_d = 1'b1;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         gnt_q      <= '0;
         gnt_id_q   <= '0;
         last_id_q  <= '1;
         hold_cnt_q <= '0;
         preempt_q  <= 1'b0;
         mode_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         gnt_id_q   <= gnt_id_d;
         last_id_q  <= last_id_d;
         hold_cnt_q <= hold_cnt_d;
         preempt_q  <= preempt_d;
         mode_q     <= mode_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = |gnt_q;
   assign preempt   = preempt_q;

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Scoreboard bench for arb4_rr_ctrl: directed steps queue the expected outputs per cycle,
// a monitor pops and compares them after each rising edge.
module tb_arb4_rr_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req;
   logic       rr_mode;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       gnt_valid;
   logic       preempt;

   int n_cmp  = 0;
   int n_fail = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [3:0] gnt;
      logic       pre;
      string      name;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   logic [3:0] inv_exp;
   logic [1:0] id_exp;

   arb4_rr_ctrl #(
      .MAX_HOLD (4),
      .CNT_W    (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .rr_mode   (rr_mode),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .gnt_valid (gnt_valid),
      .preempt   (preempt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [1:0] enc(input logic [3:0] oh);
      logic [1:0] r;
      r = 2'd0;
      for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
      return r;
   endfunction

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         inv_exp = gnt_valid ? (4'b0001 << gnt_id) : 4'b0000;
         n_cmp++;
         if (gnt !== inv_exp || gnt_valid !== (|gnt)) begin
            n_fail++;
            $display("FAIL invariant cyc=%0d: gnt=%b gnt_valid=%b gnt_id=%0d, required one-hot gnt==valid<<id",
                     cyc, gnt, gnt_valid, gnt_id);
         end
      end
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         mon_e  = sb.pop_front();
         id_exp = enc(mon_e.gnt);
         n_cmp++;
         if (mon_e.cyc != cyc || gnt !== mon_e.gnt || gnt_valid !== (|mon_e.gnt) ||
             preempt !== mon_e.pre || ((|mon_e.gnt) && gnt_id !== id_exp)) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got gnt=%b id=%0d valid=%b preempt=%b, required gnt=%b id=%0d valid=%b preempt=%b",
                     mon_e.name, cyc, gnt, gnt_id, gnt_valid, preempt,
                     mon_e.gnt, id_exp, |mon_e.gnt, mon_e.pre);
         end
      end
   end

   task automatic step(input logic [3:0] r, input logic m, input logic [3:0] eg,
                       input logic ep, input string nm);
      exp_t e;
      @(negedge clk);
      req     = r;
      rr_mode = m;
      e.cyc   = cyc + 1;
      e.gnt   = eg;
      e.pre   = ep;
      e.name  = nm;
      sb.push_back(e);
   endtask

   task automatic check_idle_now(input string nm);
      n_cmp++;
      if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b valid=%b preempt=%b, required gnt=0000 valid=0 preempt=0",
                  nm, gnt, gnt_valid, preempt);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      req     = 4'b0000;
      rr_mode = 1'b0;
      repeat (3) @(negedge clk);
      check_idle_now("reset_state");
      n_cmp++;
      if (gnt_id !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_gnt_id: got %0d, required 0", gnt_id);
      end
      rst_n = 1'b1;

      // Fixed priority: id2 wins, a later req[3] does not disturb the owner
      step(4'b0110, 1'b0, 4'b0100, 1'b0, "t1_first");
      step(4'b0110, 1'b0, 4'b0100, 1'b0, "t1_hold");
      step(4'b0110, 1'b0, 4'b0100, 1'b0, "t1_hold");
      for (int i = 0; i < 3; i++) step(4'b1110, 1'b0, 4'b0100, 1'b0, "t1_req3_wait");
      step(4'b1000, 1'b0, 4'b0000, 1'b0, "t1_release");
      step(4'b1000, 1'b0, 4'b1000, 1'b0, "t1_next");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "t1_drop");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "t1_idle");

      // Release with turnaround, fixed then round-robin
      step(4'b0010, 1'b0, 4'b0010, 1'b0, "t2_own1");
      step(4'b1011, 1'b0, 4'b0010, 1'b0, "t2_ignore_others");
      step(4'b1001, 1'b0, 4'b0000, 1'b0, "t2_release");
      step(4'b1001, 1'b0, 4'b1000, 1'b0, "t2_fixed_id3");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "t2_drop");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "t2_idle");
      step(4'b0010, 1'b1, 4'b0010, 1'b0, "t2_rr_own1");
      step(4'b1001, 1'b1, 4'b0000, 1'b0, "t2_rr_release");
      step(4'b1001, 1'b1, 4'b1000, 1'b0, "t2_rr_id3");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t2_rr_drop");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t2_rr_idle");

      // Round-robin rotation with preemption every 4 granted cycles
      for (int k = 0; k < 5; k++) begin
         for (int j = 0; j < 4; j++) step(4'b1111, 1'b1, 4'b0001 << (k % 4), 1'b0, "t3_rr_hold");
         step(4'b1111, 1'b1, 4'b0000, 1'b1, "t3_preempt");
      end
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t3_idle");

      // Hold expiry alone keeps the grant; a late competitor preempts at once
      for (int i = 0; i < 20; i++) step(4'b0100, 1'b1, 4'b0100, 1'b0, "t4_alone");
      step(4'b0110, 1'b1, 4'b0000, 1'b1, "t4_late_preempt");
      step(4'b0110, 1'b1, 4'b0010, 1'b0, "t4_rr_id1");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_drop");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle");

      // Asynchronous reset while id3 owns the grant
      step(4'b1000, 1'b0, 4'b1000, 1'b0, "t5_own3");
      step(4'b1000, 1'b0, 4'b1000, 1'b0, "t5_hold");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_idle_now("t5_async_reset");
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b1;
      step(4'b1111, 1'b1, 4'b0001, 1'b0, "t5_first_rr_id0");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_drop");
      step(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_idle");

      // Mode latched at arbitration; change during a grant waits for the next one
      step(4'b0001, 1'b0, 4'b0001, 1'b0, "t6_fixed_own0");
      for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 4'b0001, 1'b0, "t6_no_preempt");
      step(4'b1110, 1'b1, 4'b0000, 1'b0, "t6_release");
      step(4'b1110, 1'b1, 4'b0010, 1'b0, "t6_rr_id1");
      for (int i = 0; i < 3; i++) step(4'b1110, 1'b1, 4'b0010, 1'b0, "t6_rr_hold");
      step(4'b1110, 1'b1, 4'b0000, 1'b1, "t6_rr_preempt");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "t6_idle");
      step(4'b0000, 1'b0, 4'b0000, 1'b0, "t6_idle");

      repeat (3) @(negedge clk);
      n_cmp++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
